// File: rtl/sentence_player_if.sv
// Digit stream handshake between the sentence player and its consumer.
// The player offers one BCD digit plus its position; the consumer accepts with digit_ready.
interface sentence_player_if;
  logic [3:0] digit;
  logic [2:0] digit_idx;
  logic       digit_valid;
  logic       digit_ready;

  modport master (
    output digit,
    output digit_idx,
    output digit_valid,
    input  digit_ready
  );

  modport slave (
    input  digit,
    input  digit_idx,
    input  digit_valid,
    output digit_ready
  );
endinterface

// File: rtl/sentence_player.sv
// Plays a captured HHMMSS BCD time out as six handshaked digits, optionally
// separated by GAP idle cycles; rejects out-of-range times with an error pulse.
module sentence_player #(
  parameter int unsigned GAP = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [23:0]        sentence,
  output logic               busy,
  output logic               done,
  output logic               error,
  sentence_player_if.master  dig
);

  localparam int unsigned SENT_W  = 24;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned CNT_W   = 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(5);
  localparam logic [CNT_W-1:0] GAP_CNT  = CNT_W'(GAP);
  localparam bit               NO_GAP   = (GAP == 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [SENT_W-1:0]   cap_q, cap_d;
  logic [DIGIT_W-1:0]  digit_q, digit_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_inc;

  // A time is valid when every nibble is decimal and it reads as 00:00:00..24:59:59.
  function automatic logic sentence_ok(input logic [SENT_W-1:0] s);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (s[i*4 +: 4] > 4'd9) ok = 1'b0;
    end
    if (s[23:20] > 4'd2) ok = 1'b0;
    if ((s[23:20] == 4'd2) && (s[19:16] > 4'd4)) ok = 1'b0;
    if (s[15:12] > 4'd5) ok = 1'b0;
    if (s[7:4] > 4'd5) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [DIGIT_W-1:0] pick(input logic [SENT_W-1:0] s,
                                              input logic [IDX_W-1:0]  idx);
    case (idx)
      3'd0:    return s[23:20];
      3'd1:    return s[19:16];
      3'd2:    return s[15:12];
      3'd3:    return s[11:8];
      3'd4:    return s[7:4];
      default: return s[3:0];
    endcase
  endfunction

  assign idx_inc = IDX_W'(idx_q + IDX_W'(1));

  // Next-state and next-output logic; outputs are registered from these values.
  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    digit_d = digit_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    error_d = 1'b0;
    cnt_d   = cnt_q;

    if (abort) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (sentence_ok(sentence)) begin
              cap_d   = sentence;
              idx_d   = '0;
              digit_d = sentence[23:20];
              valid_d = 1'b1;
              state_d = ST_SEND;
            end else begin
              error_d = 1'b1;
            end
          end
        end
        ST_SEND: begin
          if (dig.digit_ready) begin
            if (idx_q >= LAST_IDX) begin
              valid_d = 1'b0;
              done_d  = 1'b1;
              state_d = ST_DONE;
            end else if (NO_GAP) begin
              idx_d   = idx_inc;
              digit_d = pick(cap_q, idx_inc);
            end else begin
              valid_d = 1'b0;
              cnt_d   = GAP_CNT;
              state_d = ST_GAP;
            end
          end
        end
        ST_GAP: begin
          // The last idle cycle is the one where the counter reads 1.
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d   = '0;
            idx_d   = idx_inc;
            digit_d = pick(cap_q, idx_inc);
            valid_d = 1'b1;
            state_d = ST_SEND;
          end else begin
            cnt_d = CNT_W'(cnt_q - CNT_W'(1));
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cap_q   <= '0;
      digit_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      digit_q <= digit_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dig.digit       = digit_q;
  assign dig.digit_idx   = idx_q;
  assign dig.digit_valid = valid_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign error           = error_q;

endmodule

// File: tb/tb_sentence_player.sv
// Directed bench for sentence_player: a GAP=0 instance for most scenarios and a
// GAP=3 instance for inter-digit spacing.
module tb_sentence_player;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start0, start3, abort;
  logic [23:0] sentence;
  logic        busy0, done0, error0;
  logic        busy3, done3, error3;

  int nchk = 0;
  int nbad = 0;

  sentence_player_if if0 ();
  sentence_player_if if3 ();

  sentence_player #(.GAP(0)) u0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .abort(abort),
    .sentence(sentence), .busy(busy0), .done(done0), .error(error0), .dig(if0)
  );

  sentence_player #(.GAP(3)) u3 (
    .clk(clk), .reset_n(reset_n), .start(start3), .abort(abort),
    .sentence(sentence), .busy(busy3), .done(done3), .error(error3), .dig(if3)
  );

  always #5 clk = ~clk;

  // Observation word: {digit, digit_idx, valid, busy, done, error}
  function automatic logic [10:0] obs0();
    return {if0.digit, if0.digit_idx, if0.digit_valid, busy0, done0, error0};
  endfunction

  function automatic logic [10:0] obs3();
    return {if3.digit, if3.digit_idx, if3.digit_valid, busy3, done3, error3};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [10:0] exp;
    reset_n = 1'b0; start0 = 1'b0; start3 = 1'b0; abort = 1'b0; sentence = '0;
    if0.digit_ready = 1'b0; if3.digit_ready = 1'b0;
    #12;
    exp = '0;
    nchk++;
    if (obs0() !== exp) begin
      nbad++; $display("FAIL reset_g0 got=%h want=%h", obs0(), exp);
    end
    nchk++;
    if (obs3() !== exp) begin
      nbad++; $display("FAIL reset_g3 got=%h want=%h", obs3(), exp);
    end
    #3 reset_n = 1'b1;
    tick();
    nchk++;
    if (obs0() !== exp) begin
      nbad++; $display("FAIL reset_release got=%h want=%h", obs0(), exp);
    end
  endtask

  task automatic test_basic();
    logic [3:0]  d [6];
    logic [10:0] exp;
    d = '{4'h2, 4'h3, 4'h5, 4'h9, 4'h5, 4'h9};
    sentence = 24'h235959; if0.digit_ready = 1'b1; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      exp = {d[i], 3'(i), 4'b1100};
      nchk++;
      if (obs0() !== exp) begin
        nbad++; $display("FAIL basic_digit%0d got=%h want=%h", i, obs0(), exp);
      end
      tick();
    end
    exp = {4'h9, 3'd5, 4'b0110};
    nchk++;
    if (obs0() !== exp) begin
      nbad++; $display("FAIL basic_done got=%h want=%h", obs0(), exp);
    end
    tick();
    exp = {4'h9, 3'd5, 4'b0000};
    nchk++;
    if (obs0() !== exp) begin
      nbad++; $display("FAIL basic_idle got=%h want=%h", obs0(), exp);
    end
  endtask

  task automatic test_error();
    logic [23:0] bad_s [4];
    logic [3:0]  d [6];
    logic [10:0] exp;
    bad_s = '{24'h246000, 24'h250000, 24'h1A0000, 24'h235960};
    d = '{4'h2, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0};
    if0.digit_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sentence = bad_s[k]; start0 = 1'b1;
      tick();
      start0 = 1'b0;
      exp = {4'h9, 3'd5, 4'b0001};
      nchk++;
      if (obs0() !== exp) begin
        nbad++; $display("FAIL error_pulse%0d got=%h want=%h", k, obs0(), exp);
      end
      tick();
      exp = {4'h9, 3'd5, 4'b0000};
      nchk++;
      if (obs0() !== exp) begin
        nbad++; $display("FAIL error_clear%0d got=%h want=%h", k, obs0(), exp);
      end
    end
    sentence = 24'h240000; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      exp = {d[i], 3'(i), 4'b1100};
      nchk++;
      if (obs0() !== exp) begin
        nbad++; $display("FAIL edge24_digit%0d got=%h want=%h", i, obs0(), exp);
      end
      tick();
    end
    exp = {4'h0, 3'd5, 4'b0110};
    nchk++;
    if (obs0() !== exp) begin
      nbad++; $display("FAIL edge24_done got=%h want=%h", obs0(), exp);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [3:0]  d [6];
    logic [10:0] exp;
    d = '{4'h1, 4'h2, 4'h0, 4'h3, 4'h0, 4'h4};
    sentence = 24'h120304; if0.digit_ready = 1'b0; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      for (int s = 0; s < 3; s++) begin
        if0.digit_ready = (s == 2);
        exp = {d[i], 3'(i), 4'b1100};
        nchk++;
        if (obs0() !== exp) begin
          nbad++; $display("FAIL bp_digit%0d_c%0d got=%h want=%h", i, s, obs0(), exp);
        end
        tick();
      end
    end
    if0.digit_ready = 1'b0;
    exp = {4'h4, 3'd5, 4'b0110};
    nchk++;
    if (obs0() !== exp) begin
      nbad++; $display("FAIL bp_done got=%h want=%h", obs0(), exp);
    end
    tick();
  endtask

  task automatic test_gap();
    logic [3:0]  d [6];
    logic [10:0] exp;
    d = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h3};
    sentence = 24'h010203; if3.digit_ready = 1'b1; start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      exp = {d[i], 3'(i), 4'b1100};
      nchk++;
      if (obs3() !== exp) begin
        nbad++; $display("FAIL gap_digit%0d got=%h want=%h", i, obs3(), exp);
      end
      tick();
      if (i < 5) begin
        for (int g = 0; g < 3; g++) begin
          exp = {d[i], 3'(i), 4'b0100};
          nchk++;
          if (obs3() !== exp) begin
            nbad++; $display("FAIL gap_idle%0d_%0d got=%h want=%h", i, g, obs3(), exp);
          end
          tick();
        end
      end
    end
    exp = {4'h3, 3'd5, 4'b0110};
    nchk++;
    if (obs3() !== exp) begin
      nbad++; $display("FAIL gap_done got=%h want=%h", obs3(), exp);
    end
    tick();
    exp = {4'h3, 3'd5, 4'b0000};
    nchk++;
    if (obs3() !== exp) begin
      nbad++; $display("FAIL gap_idle_end got=%h want=%h", obs3(), exp);
    end
  endtask

  task automatic test_abort();
    logic [10:0] exp;
    sentence = 24'h235959; if0.digit_ready = 1'b0; start0 = 1'b1;
    tick();
    start0 = 1'b0; if0.digit_ready = 1'b1;
    tick(); tick(); tick();
    if0.digit_ready = 1'b0;
    exp = {4'h9, 3'd3, 4'b1100};
    nchk++;
    if (obs0() !== exp) begin
      nbad++; $display("FAIL abort_pre got=%h want=%h", obs0(), exp);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp = {4'h9, 3'd3, 4'b0000};
    for (int c = 0; c < 2; c++) begin
      nchk++;
      if (obs0() !== exp) begin
        nbad++; $display("FAIL abort_idle%0d got=%h want=%h", c, obs0(), exp);
      end
      tick();
    end
    // abort wins over a simultaneous start
    sentence = 24'h111111; start0 = 1'b1; abort = 1'b1;
    tick();
    start0 = 1'b0; abort = 1'b0;
    nchk++;
    if (obs0() !== exp) begin
      nbad++; $display("FAIL abort_start got=%h want=%h", obs0(), exp);
    end
    tick();
    nchk++;
    if (obs0() !== exp) begin
      nbad++; $display("FAIL abort_start_after got=%h want=%h", obs0(), exp);
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] exp;
    sentence = 24'h235959; if0.digit_ready = 1'b1; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    exp = {4'h3, 3'd1, 4'b1100};
    nchk++;
    if (obs0() !== exp) begin
      nbad++; $display("FAIL rst_pre got=%h want=%h", obs0(), exp);
    end
    reset_n = 1'b0;
    #1;
    exp = '0;
    nchk++;
    if (obs0() !== exp) begin
      nbad++; $display("FAIL rst_async got=%h want=%h", obs0(), exp);
    end
    #3 reset_n = 1'b1;
    tick();
    nchk++;
    if (obs0() !== exp) begin
      nbad++; $display("FAIL rst_after got=%h want=%h", obs0(), exp);
    end
    sentence = 24'h000000; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      exp = {4'h0, 3'(i), 4'b1100};
      nchk++;
      if (obs0() !== exp) begin
        nbad++; $display("FAIL zeros_digit%0d got=%h want=%h", i, obs0(), exp);
      end
      tick();
    end
    exp = {4'h0, 3'd5, 4'b0110};
    nchk++;
    if (obs0() !== exp) begin
      nbad++; $display("FAIL zeros_done got=%h want=%h", obs0(), exp);
    end
    tick();
  endtask

  task automatic test_start_held();
    logic [3:0]  d [6];
    logic [10:0] exp;
    d = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
    sentence = 24'h123456; if0.digit_ready = 1'b1; start0 = 1'b1;
    tick();
    sentence = 24'h111111;
    for (int i = 0; i < 6; i++) begin
      exp = {d[i], 3'(i), 4'b1100};
      nchk++;
      if (obs0() !== exp) begin
        nbad++; $display("FAIL held_digit%0d got=%h want=%h", i, obs0(), exp);
      end
      tick();
    end
    exp = {4'h6, 3'd5, 4'b0110};
    nchk++;
    if (obs0() !== exp) begin
      nbad++; $display("FAIL held_done got=%h want=%h", obs0(), exp);
    end
    start0 = 1'b0;
    tick();
    exp = {4'h6, 3'd5, 4'b0000};
    nchk++;
    if (obs0() !== exp) begin
      nbad++; $display("FAIL held_idle got=%h want=%h", obs0(), exp);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_error();
    test_backpressure();
    test_gap();
    test_abort();
    test_reset_mid();
    test_start_held();
    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end

endmodule

// File: doc/sentence_player.md
SENTENCE_PLAYER -- requirements
Module: sentence_player

Interface
REQ-001 Parameter GAP, default 0, number of idle cycles inserted between consecutive digit handshakes (0..255).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request to play back sentence; sampled only in IDLE.
REQ-005 abort  input  1  cancels playback; returns to IDLE next edge.
REQ-006 sentence  input  24  BCD time HHMMSS, [23:20] hours tens ... [3:0] seconds units.
REQ-007 digit  output  4  current BCD digit being offered.
REQ-008 digit_idx  output  3  position of digit, 0 = [23:20] ... 5 = [3:0].
REQ-009 digit_valid  output  1  digit/digit_idx valid; held until handshake.
REQ-010 digit_ready  input  1  consumer accepts digit when high with digit_valid.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse after sixth digit accepted.
REQ-013 error  output  1  one-cycle pulse when start rejected for invalid sentence.

Function
REQ-014 States SHALL be IDLE, SEND, GAP, DONE; encoding free.
REQ-015 Sentence validity SHALL be: every nibble <= 9; hours tens <= 2; hours units <= 4 when hours tens = 2; minutes tens <= 5; seconds tens <= 5.
REQ-016 IDLE: start=1, abort=0, sentence valid -> capture sentence into internal 24-bit register, digit_idx=0, go SEND.
REQ-017 IDLE: start=1, abort=0, sentence invalid -> error=1 next cycle for exactly one cycle, stay IDLE, internal register unchanged.
REQ-018 Captured register SHALL be the only digit source; sentence input changes after capture SHALL not affect output.
REQ-019 SEND: digit_valid=1, digit = captured nibble selected by digit_idx, digit_idx stable while digit_ready=0.
REQ-020 SEND handshake (digit_valid & digit_ready) with digit_idx=5 -> DONE.
REQ-021 SEND handshake with digit_idx<5 and GAP=0 -> stay SEND, digit_idx+1 next cycle (back-to-back digits).
REQ-022 SEND handshake with digit_idx<5 and GAP>0 -> GAP with gap counter loaded; digit_valid=0 for exactly GAP cycles, then SEND with digit_idx+1.
REQ-023 DONE: done=1 for one cycle, digit_valid=0, then IDLE.
REQ-024 Latency: start accepted at edge N -> digit_valid=1 from cycle after N; with GAP=0 and digit_ready held 1, handshakes on six consecutive edges, done high on seventh cycle.
REQ-025 start outside IDLE SHALL be ignored (no restart, no error).
REQ-026 abort=1 in any state -> IDLE next edge, digit_valid=0, no done, no error; abort and start together in IDLE -> abort wins, nothing captured.
REQ-027 digit_idx SHALL never exceed 5; no wrap to 6/7.
REQ-028 Outputs when digit_valid=0: digit and digit_idx hold last value (0 after reset).

Reset
REQ-029 reset_n=0 SHALL immediately force IDLE, digit=0, digit_idx=0, digit_valid=0, busy=0, done=0, error=0, captured register=0, gap counter=0.
REQ-030 Reset asserted mid-playback SHALL discard playback; after release block waits in IDLE for new start.
REQ-031 Deassertion SHALL take effect on the first rising clk edge after release; no output pulses generated by release.

Verification
REQ-032 GAP=0, sentence=24'h235959, start pulse, digit_ready=1 -> digits 2,3,5,9,5,9 with idx 0..5 on six consecutive cycles, done one cycle after, busy falls with done cycle end.
REQ-033 sentence=24'h246000 (minutes tens 6), start -> error pulse one cycle, busy stays 0, no digit_valid; sentence=24'h250000 -> error; 24'h240000 -> accepted.
REQ-034 Backpressure: sentence=24'h120304, digit_ready toggling 0,0,1 per digit -> each digit held stable across stall cycles, order 1,2,0,3,0,4 preserved.
REQ-035 GAP=3, sentence=24'h010203, digit_ready=1 -> digit_valid low exactly 3 cycles between each of the six handshakes; total 6+5*3 cycles to last handshake.
REQ-036 abort asserted while digit_idx=3, and separately reset_n pulsed low mid-SEND -> IDLE, digit_valid=0, no done; new start with 24'h000000 plays six zeros normally.
REQ-037 start held high through playback with sentence changed to 24'h111111 after capture -> original digits played once, no restart.
